float_add_pipe: RTL
===================

FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair A/B/sub presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port A  input  W  IEEE-style operand A.
REQ-008 SHALL have port B  input  W  IEEE-style operand B.
REQ-009 SHALL have port sub  input  1  0: A+B, 1: A-B (B sign inverted).
REQ-010 SHALL have port out_valid  output  1  S and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port S  output  W  rounded result.
REQ-013 SHALL have port overflow  output  1  result exceeded max finite, S = signed infinity.
REQ-014 SHALL have port underflow  output  1  nonzero exact result flushed to signed zero.
REQ-015 SHALL have port invalid  output  1  NaN operand or inf-inf; S = canonical NaN.

Function
REQ-016 SHALL accept an operation when in_valid && in_ready; SHALL present the result with out_valid exactly 3 cycles later when not stalled.
REQ-017 SHALL implement stage 1: unpack, effective-sign resolution, operand swap so |X|>=|Y|, alignment shift of Y with guard, round and sticky bits (sticky = OR of all bits shifted past round).
REQ-018 SHALL implement stage 2: MAN_W+4-bit magnitude add or subtract; subtraction never produces negative magnitude (swap guarantees).
REQ-019 SHALL implement stage 3: leading-one normalisation (left or one-bit right), round-to-nearest-even, mantissa-carry renormalisation, pack, flag generation.
REQ-020 SHALL treat alignment shift >= MAN_W+3 as Y contributing sticky only.
REQ-021 SHALL flush subnormal inputs (exp=0) to signed zero before use.
REQ-022 SHALL return the other operand unchanged when one operand is zero (sub applied to B's sign).
REQ-023 SHALL produce +0 for an exact-zero sum of opposite-sign operands; (-0)+(-0) SHALL give -0.
REQ-024 SHALL produce S = signed infinity, overflow=1, when the rounded exponent reaches all-ones.
REQ-025 SHALL produce S = signed zero, underflow=1, when the normalised exponent falls below 1 and the exact result is nonzero.
REQ-026 SHALL produce canonical NaN {0, all-ones exp, fraction MSB=1, rest 0} with invalid=1 for any NaN input or inf+(-inf) effective; inf plus finite SHALL give that inf, flags 0.
REQ-027 SHALL use a global stall: in_ready = !(out_valid && !out_ready); while stalled every stage SHALL hold contents; a bubble SHALL never overwrite a held result.
REQ-028 SHALL advance stage valid bits independently of data so bubbles propagate at one stage per cycle.
REQ-029 SHALL keep S and flags stable while out_valid && !out_ready.
REQ-030 SHALL preserve issue order; no operation SHALL be dropped or duplicated.

Reset
REQ-031 SHALL, on rst_n low, immediately clear all stage valid bits, out_valid=0, S=0, overflow=underflow=invalid=0, regardless of clock.
REQ-032 SHALL discard all in-flight operations on reset; in_ready SHALL be 1 in the first cycle after rst_n rises.

Verification (EXP_W=8, MAN_W=23)
REQ-033 SHALL cover: A=0x3F800000, B=0x40000000, sub=0 -> S=0x40400000, flags 0, out_valid 3 cycles after accept.
REQ-034 SHALL cover: A=0x3F800000, B=0x33800000 -> S=0x3F800000; A=0x3F800001, B=0x33800000 -> S=0x3F800002 (ties-to-even).
REQ-035 SHALL cover: A=B=0x3F800000, sub=1 -> S=0x00000000; A=B=0x7F7FFFFF, sub=0 -> S=0x7F800000, overflow=1.
REQ-036 SHALL cover: A=0x7F800000, B=0x7F800000, sub=1 -> S=0x7FC00000, invalid=1; A=0x00400000 (subnormal), B=0x3F800000 -> S=0x3F800000.
REQ-037 SHALL cover: out_ready=0 while issuing 4 back-to-back ops -> in_ready drops after pipe fills, first result held stable; out_ready=1 -> all 4 results delivered in order, one per cycle.
REQ-038 SHALL cover: rst_n pulsed low mid-stream with 3 ops in flight -> out_valid falls asynchronously, no stale result appears after reset release.

Source files
------------

// File: rtl/float_add_pipe.sv
// Three-stage IEEE-style float adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// Latency 3 cycles; a single global stall freezes every stage while the output waits on out_ready.
module float_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   S,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int N   = MAN_W + 4;           // hidden, fraction, guard, round, sticky
  localparam int EW  = EXP_W + 2;           // exponent with sign/headroom
  localparam int LZW = $clog2(N);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // ---------------- stage 1: unpack, specials, swap, align ----------------
  logic                 sa, sb, sx;
  logic [EXP_W-1:0]     ea, eb, ex, ey, dexp;
  logic [MAN_W-1:0]     ma, mb, mx, my;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_gt;
  logic [N-1:0]         y_ext, y_al;
  logic [2*N-1:0]       y_wide;
  logic                 c1_spec, c1_inv;
  logic [W-1:0]         c1_res;

  assign sa     = A[W-1];
  assign ea     = A[W-2:MAN_W];
  assign ma     = A[MAN_W-1:0];
  assign sb     = B[W-1] ^ sub;
  assign eb     = B[W-2:MAN_W];
  assign mb     = B[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (ma == '0);
  assign b_inf  = (eb == EXP_MAX) && (mb == '0);
  assign a_nan  = (ea == EXP_MAX) && (ma != '0);
  assign b_nan  = (eb == EXP_MAX) && (mb != '0);
  assign b_gt   = {eb, mb} > {ea, ma};

  always_comb begin
    c1_spec = 1'b1;
    c1_inv  = 1'b0;
    c1_res  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      c1_res = QNAN;
      c1_inv = 1'b1;
    end else if (a_inf) begin
      c1_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      c1_res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      c1_res = {sb, B[W-2:0]};
    end else if (b_zero) begin
      c1_res = A;
    end else begin
      c1_spec = 1'b0;
    end
  end

  always_comb begin
    sx     = b_gt ? sb : sa;
    ex     = b_gt ? eb : ea;
    mx     = b_gt ? mb : ma;
    ey     = b_gt ? ea : eb;
    my     = b_gt ? ma : mb;
    dexp   = ex - ey;
    y_ext  = {1'b1, my, 3'b000};
    y_wide = {y_ext, {N{1'b0}}} >> dexp;
    // Far-shifted Y still matters for rounding, so it survives as a lone sticky bit.
    if (int'(dexp) >= N)
      y_al = {{(N-1){1'b0}}, 1'b1};
    else
      y_al = {y_wide[2*N-1:N+1], y_wide[N] | (|y_wide[N-1:0])};
  end

  logic               s1_vld, s1_spec, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]       s1_res;
  logic [EXP_W-1:0]   s1_exp;
  logic [N-1:0]       s1_x, s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_spec <= 1'b0;
      s1_inv  <= 1'b0;
      s1_sign <= 1'b0;
      s1_sub  <= 1'b0;
      s1_res  <= '0;
      s1_exp  <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_spec <= c1_spec;
      s1_inv  <= c1_inv;
      s1_sign <= sx;
      s1_sub  <= sa ^ sb;
      s1_res  <= c1_res;
      s1_exp  <= ex;
      s1_x    <= {1'b1, mx, 3'b000};
      s1_y    <= y_al;
    end
  end

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic [N:0] c2_sum;
  assign c2_sum = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y})
                         : ({1'b0, s1_x} + {1'b0, s1_y});

  logic               s2_vld, s2_spec, s2_inv, s2_sign;
  logic [W-1:0]       s2_res;
  logic [EXP_W-1:0]   s2_exp;
  logic [N:0]         s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_spec <= 1'b0;
      s2_inv  <= 1'b0;
      s2_sign <= 1'b0;
      s2_res  <= '0;
      s2_exp  <= '0;
      s2_sum  <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_spec <= s1_spec;
      s2_inv  <= s1_inv;
      s2_sign <= s1_sign;
      s2_res  <= s1_res;
      s2_exp  <= s1_exp;
      s2_sum  <= c2_sum;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZW-1:0]   lz;
  logic [N-1:0]     norm;
  logic [MAN_W:0]   mant;
  logic             rnd, stk, rnd_up;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0]    e_n, e_r;
  logic [W-1:0]     c3_s;
  logic             c3_ovf, c3_unf, c3_inv;

  always_comb begin
    lz = '0;
    for (int i = 0; i < N; i++)
      if (s2_sum[i]) lz = LZW'(N - 1 - i);
    norm = s2_sum[N-1:0] << lz;
    if (s2_sum[N]) begin
      mant = s2_sum[N:4];
      rnd  = s2_sum[3];
      stk  = |s2_sum[2:0];
      e_n  = {2'b00, s2_exp} + EW'(1);
    end else begin
      mant = norm[N-1:3];
      rnd  = norm[2];
      stk  = |norm[1:0];
      e_n  = {2'b00, s2_exp} - EW'(lz);
    end
    rnd_up = rnd & (stk | mant[0]);
    mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
    e_r    = mant_r[MAN_W+1] ? e_n + EW'(1) : e_n;
    frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    c3_s   = {s2_sign, e_r[EXP_W-1:0], frac};
    c3_ovf = 1'b0;
    c3_unf = 1'b0;
    c3_inv = 1'b0;
    if (s2_spec) begin
      c3_s   = s2_res;
      c3_inv = s2_inv;
    end else if (s2_sum == '0) begin
      c3_s = '0;  // exact cancellation is +0 under round-to-nearest
    end else if ($signed(e_n) < $signed(EW'(1))) begin
      c3_s   = {s2_sign, {(W-1){1'b0}}};
      c3_unf = 1'b1;
    end else if ($signed(e_r) >= $signed({2'b00, EXP_MAX})) begin
      c3_s   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      c3_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_vld;
      S         <= c3_s;
      overflow  <= c3_ovf;
      underflow <= c3_unf;
      invalid   <= c3_inv;
    end
  end

endmodule
